bist_signature_checker: RTL and testbench

- Datapath stage directly downstream of the BIST control state machine.
- Consumes its `init`, `running`, `mode` and `finish` strobes.
- Drives pseudo-random test patterns (Galois LFSR) into the circuit under test and compacts the returned responses into a signature (MISR).
- At finish, compares the signature against a golden value and reports pass/fail, held until the next run.

---
 rtl/bist_pkg.sv | 12 +
 rtl/bist_lfsr.sv | 45 ++++
 rtl/bist_signature_checker.sv | 147 ++++++++++++++
 tb/tb_bist_signature_checker.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST signature checker.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_e;

  localparam int COUNT_W = 16;

endpackage

// File: rtl/bist_lfsr.sv
// WIDTH-bit Galois shift register; used both as the pattern LFSR (data_in = 0)
// and as the response MISR (data_in = CUT response).
module bist_lfsr #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
    step = x[0] ? ((x >> 1'b1) ^ POLY) : (x >> 1'b1);
  endfunction

  // Load has priority over a shift so a restart never folds in a stale response.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = SEED;
    end else if (enable) begin
      q_d = step(q_q) ^ data_in;
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bist_signature_checker.sv
// Pattern generation, response compaction and golden-signature compare for BIST.
// Optional build macro BIST_ERR_INJECT_EN adds err_inject to flip response bit 0.
module bist_signature_checker
  import bist_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] LFSR_SEED = 8'h01,
  parameter logic [WIDTH-1:0] LFSR_POLY = 8'hB8,
  parameter logic [WIDTH-1:0] MISR_POLY = 8'hB8,
  parameter logic [WIDTH-1:0] GOLDEN    = 8'h5C
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               init,
  input  logic               running,
  input  logic               mode,
  input  logic               finish,
  input  logic [WIDTH-1:0]   dut_response,
`ifdef BIST_ERR_INJECT_EN
  input  logic               err_inject,
`endif
  output logic [WIDTH-1:0]   pattern,
  output logic [WIDTH-1:0]   signature,
  output logic [COUNT_W-1:0] pattern_count,
  output logic               done,
  output logic               pass,
  output logic               fail
);

  localparam logic [WIDTH-1:0] PAT_SEED =
    (LFSR_SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : LFSR_SEED;
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  bist_state_e        state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               compact_s;
  logic               finish_s;
  logic [WIDTH-1:0]   resp_s;
  logic [WIDTH-1:0]   sig_after_s;

  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] x);
    misr_step = x[0] ? ((x >> 1'b1) ^ MISR_POLY) : (x >> 1'b1);
  endfunction

  // Qualify strobes; init overrides both compaction and finish.
  always_comb begin
    compact_s = (state_q == RUN) && running && mode && !init;
    finish_s  = (state_q == RUN) && finish && !init;
`ifdef BIST_ERR_INJECT_EN
    resp_s    = dut_response ^ {{(WIDTH-1){1'b0}}, (err_inject & compact_s)};
`else
    resp_s    = dut_response;
`endif
    if (compact_s) begin
      sig_after_s = misr_step(signature) ^ resp_s;
    end else begin
      sig_after_s = signature;
    end
  end

  bist_lfsr #(.WIDTH(WIDTH), .POLY(LFSR_POLY), .SEED(PAT_SEED)) u_pattern_lfsr (
    .clock   (clock),
    .reset   (reset),
    .load    (init),
    .enable  (compact_s),
    .data_in ({WIDTH{1'b0}}),
    .q       (pattern)
  );

  bist_lfsr #(.WIDTH(WIDTH), .POLY(MISR_POLY), .SEED({WIDTH{1'b0}})) u_misr (
    .clock   (clock),
    .reset   (reset),
    .load    (init),
    .enable  (compact_s),
    .data_in (resp_s),
    .q       (signature)
  );

  // Control state transitions.
  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     state_d = finish ? DONE : RUN;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Counter and result flags; the compare sees this cycle's compaction.
  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    if (init) begin
      count_d = {COUNT_W{1'b0}};
      done_d  = 1'b0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
    end else begin
      if (compact_s && (count_q != COUNT_MAX)) begin
        count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
      end else begin
        count_d = count_q;
      end
      if (finish_s) begin
        done_d = 1'b1;
        pass_d = (sig_after_s == GOLDEN);
        fail_d = (sig_after_s != GOLDEN);
      end else begin
        done_d = done_q;
        pass_d = pass_q;
        fail_d = fail_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= {COUNT_W{1'b0}};
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign pattern_count = count_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;

endmodule

// File: tb/tb_bist_signature_checker.sv
// Directed and randomized bench for bist_signature_checker against a behavioural model.
module tb_bist_signature_checker;

  localparam logic [7:0] SEED  = 8'h01;
  localparam logic [7:0] LPOLY = 8'hB8;
  localparam logic [7:0] MPOLY = 8'hB8;
  localparam logic [7:0] GOLD  = 8'h5C;

  logic        clock = 1'b0;
  logic        reset;
  logic        init, running, mode, finish;
  logic [7:0]  dut_response;
  logic        err_inject;
  logic [7:0]  pattern, signature;
  logic [15:0] pattern_count;
  logic        done, pass, fail;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 run, 2 done
  int          m_phase;
  int          m_pat, m_sig, m_cnt;
  bit          m_done, m_pass, m_fail;

  always #5 clock = ~clock;

  bist_signature_checker dut (
    .clock         (clock),
    .reset         (reset),
    .init          (init),
    .running       (running),
    .mode          (mode),
    .finish        (finish),
    .dut_response  (dut_response),
`ifdef BIST_ERR_INJECT_EN
    .err_inject    (err_inject),
`endif
    .pattern       (pattern),
    .signature     (signature),
    .pattern_count (pattern_count),
    .done          (done),
    .pass          (pass),
    .fail          (fail)
  );

  function automatic int step(input int x, input int p);
    if (x % 2 == 1) return (x / 2) ^ p;
    else            return x / 2;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pat = SEED; m_sig = 0; m_cnt = 0;
    m_done = 0; m_pass = 0; m_fail = 0;
  endtask

  task automatic model_edge();
    int resp;
    resp = dut_response;
`ifdef BIST_ERR_INJECT_EN
    if (err_inject) resp = resp ^ 1;
`endif
    if (init) begin
      m_phase = 1; m_pat = SEED; m_sig = 0; m_cnt = 0;
      m_done = 0; m_pass = 0; m_fail = 0;
    end else if (m_phase == 1) begin
      if (running && mode) begin
        m_sig = step(m_sig, MPOLY) ^ resp;
        m_pat = step(m_pat, LPOLY);
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
      if (finish) begin
        m_phase = 2; m_done = 1;
        m_pass = (m_sig == GOLD); m_fail = (m_sig != GOLD);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pattern"},   {8'h00, pattern},   16'(m_pat));
    chk({tag, ".signature"}, {8'h00, signature}, 16'(m_sig));
    chk({tag, ".count"},     pattern_count,      16'(m_cnt));
    chk({tag, ".done"},      {15'd0, done},      {15'd0, m_done});
    chk({tag, ".pass"},      {15'd0, pass},      {15'd0, m_pass});
    chk({tag, ".fail"},      {15'd0, fail},      {15'd0, m_fail});
  endtask

  task automatic drive(input bit i, input bit r, input bit m, input bit f, input logic [7:0] d);
    init = i; running = r; mode = m; finish = f; dut_response = d;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] exp_pat [4];
    logic [7:0] exp_sig [3];
    exp_pat = '{8'hB8, 8'h5C, 8'h2E, 8'h17};
    exp_sig = '{8'h01, 8'h00, 8'h5C};
    err_inject = 1'b0;
    reset = 1'b0;
    drive(0, 0, 0, 0, 8'h00);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst.pattern",   {8'h00, pattern},   16'h0001);
    chk("rst.signature", {8'h00, signature}, 16'h0000);
    chk("rst.flags",     {13'd0, done, pass, fail}, 16'h0000);
    chk_model("rst");
    reset = 1'b1;

    // Patterns with zero response
    drive(1, 0, 0, 0, 8'h00); tick();
    chk("init.pattern", {8'h00, pattern}, 16'h0001);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 1, 0, 8'h00); tick();
      chk("seq.pattern", {8'h00, pattern}, {8'h00, exp_pat[k]});
      chk("seq.signature", {8'h00, signature}, 16'h0000);
    end
    chk("seq.count", pattern_count, 16'd4);
    chk_model("seq");

    // Loopback to golden
    drive(1, 0, 0, 0, 8'h00); tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 0, 8'(m_pat)); tick();
      chk("loop.signature", {8'h00, signature}, {8'h00, exp_sig[k]});
    end
    drive(0, 0, 0, 1, 8'h00); tick();
    chk("loop.result", {13'd0, done, pass, fail}, 16'b110);
    chk_model("loop");
    drive(0, 0, 0, 1, 8'h00); tick();
    chk_model("done_hold");

    // Loopback with a check cycle inserted
    drive(1, 0, 0, 0, 8'h00); tick();
    drive(0, 1, 1, 0, 8'(m_pat)); tick();
    drive(0, 1, 0, 0, 8'hFF); tick();
    chk("chk.hold_sig", {8'h00, signature}, 16'h0001);
    drive(0, 1, 1, 0, 8'(m_pat)); tick();
    drive(0, 1, 1, 1, 8'(m_pat)); tick();
    chk("chk.signature", {8'h00, signature}, 16'h005C);
    chk("chk.count", pattern_count, 16'd3);
    chk("chk.result", {13'd0, done, pass, fail}, 16'b110);

`ifdef BIST_ERR_INJECT_EN
    drive(1, 0, 0, 0, 8'h00); tick();
    err_inject = 1'b1;
    drive(0, 1, 1, 0, 8'(m_pat)); tick();
    chk("inj.sig0", {8'h00, signature}, 16'h0000);
    err_inject = 1'b0;
    drive(0, 1, 1, 0, 8'(m_pat)); tick();
    chk("inj.sig1", {8'h00, signature}, 16'h00B8);
    drive(0, 1, 1, 0, 8'(m_pat)); tick();
    chk("inj.sig2", {8'h00, signature}, 16'h0000);
    drive(0, 0, 0, 1, 8'h00); tick();
    chk("inj.result", {13'd0, done, pass, fail}, 16'b101);
`endif

    // Reset mid-run, then finish without init
    drive(1, 0, 0, 0, 8'h00); tick();
    drive(0, 1, 1, 0, 8'h3C); tick();
    drive(0, 1, 1, 0, 8'hA5); tick();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("midrst.pattern", {8'h00, pattern}, 16'h0001);
    chk("midrst.signature", {8'h00, signature}, 16'h0000);
    chk("midrst.count", pattern_count, 16'd0);
    @(negedge clock);
    reset = 1'b1;
    drive(0, 1, 1, 1, 8'h77); tick();
    chk("midrst.done", {15'd0, done}, 16'd0);
    chk_model("midrst");

    // Randomized traffic, occasionally looping back so passes occur
    for (int n = 0; n < 600; n++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 3) == 0) ? 8'(m_pat) : 8'($urandom);
      drive($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, d);
`ifdef BIST_ERR_INJECT_EN
      err_inject = ($urandom_range(0, 7) == 0);
`endif
      tick();
      chk_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
